// File: rtl/combat_arbiter_pkg.sv
// Shared types and helpers for the combat arbiter.
// Provides player state codes, game_state and winner encodings,
// the box payload struct and small arithmetic helpers.
package combat_arbiter_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned HEALTH_W = 3;
  localparam int unsigned WINS_W   = 2;
  localparam int unsigned PSTATE_W = 4;

  // Player current_state codes as reported by the player blocks
  typedef enum logic [PSTATE_W-1:0] {
    PS_IDLE        = 4'd0,
    PS_WALK_FWD    = 4'd1,
    PS_WALK_BACK   = 4'd2,
    PS_ATK_START   = 4'd3,
    PS_ATK_END     = 4'd4,
    PS_ATK_RECOVER = 4'd5,
    PS_BLOCK       = 4'd6,
    PS_HITSTUN     = 4'd7
  } pstate_e;

  // Active hit frames are the end phase of the basic attack
  localparam logic [PSTATE_W-1:0] HIT_STATE_DEF = PSTATE_W'(PS_ATK_END);

  typedef enum logic [1:0] {
    GS_FIGHT   = 2'b00,
    GS_KO      = 2'b01,
    GS_RESTART = 2'b10,
    GS_OVER    = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Box with corners in whatever order the player block reports them
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

  typedef struct packed {
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
  } span_t;

  // Order a corner pair as (min, max)
  function automatic span_t norm_span(input logic [COORD_W-1:0] a,
                                      input logic [COORD_W-1:0] b);
    span_t s;
    if (a <= b) begin
      s.lo = a;
      s.hi = b;
    end else begin
      s.lo = b;
      s.hi = a;
    end
    return s;
  endfunction

  // Health decrement that stops at zero
  function automatic logic [HEALTH_W-1:0] sat_dec(input logic [HEALTH_W-1:0] h);
    return (h == '0) ? h : h - HEALTH_W'(1);
  endfunction

endpackage

// File: rtl/combat_arbiter_if.sv
// Player/HUD-facing bundle of the combat arbiter.
// master: player blocks / top level drive frame_tick, states and boxes.
// slave : the arbiter drives health, took_hit, wins, winner, game_state
//         and players_rst.
interface combat_arbiter_if;
  import combat_arbiter_pkg::*;

  logic                  frame_tick;
  logic [PSTATE_W-1:0]   p1_state;
  logic [PSTATE_W-1:0]   p2_state;
  logic [COORD_W-1:0]    p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
  logic [COORD_W-1:0]    p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
  logic [COORD_W-1:0]    p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [COORD_W-1:0]    p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;

  logic [HEALTH_W-1:0]   p1_health;
  logic [HEALTH_W-1:0]   p2_health;
  logic                  p1_took_hit;
  logic                  p2_took_hit;
  logic [WINS_W-1:0]     p1_wins;
  logic [WINS_W-1:0]     p2_wins;
  logic [1:0]            winner;
  logic [1:0]            game_state;
  logic                  players_rst;

  modport master (
    output frame_tick, p1_state, p2_state,
    output p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
    output p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
    output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
    output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
    input  p1_health, p2_health, p1_took_hit, p2_took_hit,
    input  p1_wins, p2_wins, winner, game_state, players_rst
  );

  modport slave (
    input  frame_tick, p1_state, p2_state,
    input  p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
    input  p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
    input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
    input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
    output p1_health, p2_health, p1_took_hit, p2_took_hit,
    output p1_wins, p2_wins, winner, game_state, players_rst
  );

endinterface

// File: rtl/box_overlap.sv
// Combinational inclusive overlap test between two boxes with unordered
// corners.
// a_i, b_i  : boxes (x1/x2/y1/y2 in any order per axis)
// overlap_o : 1 when the boxes share at least one point on both axes
module box_overlap
  import combat_arbiter_pkg::*;
(
  input  box_t a_i,
  input  box_t b_i,
  output logic overlap_o
);

  span_t ax, ay, bx, by;

  always_comb begin
    ax = norm_span(a_i.x1, a_i.x2);
    ay = norm_span(a_i.y1, a_i.y2);
    bx = norm_span(b_i.x1, b_i.x2);
    by = norm_span(b_i.y1, b_i.y2);
    // Edge contact counts as overlap
    overlap_o = (ax.lo <= bx.hi) && (bx.lo <= ax.hi) &&
                (ay.lo <= by.hi) && (by.lo <= ay.hi);
  end

endmodule

// File: rtl/combat_arbiter.sv
// Round-level combat controller for the two-player fighter.
// Evaluates hits once per frame, tracks health and round wins, sequences
// FIGHT -> KO -> RESTART/OVER and pulses players_rst between rounds.
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of combat_arbiter_if (ticks, states, boxes in;
//            health, took_hit, wins, winner, game_state, players_rst out)
module combat_arbiter
  import combat_arbiter_pkg::*;
#(
  parameter int unsigned         MAX_HEALTH    = 3,
  parameter int unsigned         ROUNDS_TO_WIN = 2,
  parameter int unsigned         KO_FRAMES     = 60,
  parameter logic [PSTATE_W-1:0] HIT_STATE     = HIT_STATE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  combat_arbiter_if.slave  bus
);

  localparam int unsigned KO_W = (KO_FRAMES > 2) ? $clog2(KO_FRAMES) : 1;
  localparam logic [HEALTH_W-1:0] HP_MAX    = HEALTH_W'(MAX_HEALTH);
  localparam logic [WINS_W-1:0]   WINS_MAX  = WINS_W'(ROUNDS_TO_WIN);
  localparam logic [KO_W-1:0]     KO_LAST   = KO_W'(KO_FRAMES - 1);

  // Registered state
  game_state_e          state_q;
  winner_e              winner_q;
  logic [HEALTH_W-1:0]  p1_health_q, p2_health_q;
  logic                 p1_took_hit_q, p2_took_hit_q;
  logic [WINS_W-1:0]    p1_wins_q, p2_wins_q;
  logic                 players_rst_q;
  logic                 p1_armed_q, p2_armed_q;
  logic [KO_W-1:0]      ko_cnt_q;

  // Next-state candidates for a FIGHT frame
  logic [HEALTH_W-1:0]  p1_health_d, p2_health_d;
  logic [WINS_W-1:0]    p1_wins_d, p2_wins_d;
  logic                 p1_armed_d, p2_armed_d;
  winner_e              winner_d;
  logic                 ko_c;
  logic                 match_over_c;

  box_t p1_hit_box, p2_hit_box, p1_hurt_box, p2_hurt_box;
  logic ov_12_c, ov_21_c;
  logic p1_hit_c, p2_hit_c;

  assign p1_hit_box  = '{x1: bus.p1_hit_x1,  x2: bus.p1_hit_x2,
                         y1: bus.p1_hit_y1,  y2: bus.p1_hit_y2};
  assign p2_hit_box  = '{x1: bus.p2_hit_x1,  x2: bus.p2_hit_x2,
                         y1: bus.p2_hit_y1,  y2: bus.p2_hit_y2};
  assign p1_hurt_box = '{x1: bus.p1_hurt_x1, x2: bus.p1_hurt_x2,
                         y1: bus.p1_hurt_y1, y2: bus.p1_hurt_y2};
  assign p2_hurt_box = '{x1: bus.p2_hurt_x1, x2: bus.p2_hurt_x2,
                         y1: bus.p2_hurt_y1, y2: bus.p2_hurt_y2};

  // P1 hitbox against P2 hurtbox
  box_overlap u_p1_on_p2 (
    .a_i       (p1_hit_box),
    .b_i       (p2_hurt_box),
    .overlap_o (ov_12_c)
  );

  // P2 hitbox against P1 hurtbox
  box_overlap u_p2_on_p1 (
    .a_i       (p2_hit_box),
    .b_i       (p1_hurt_box),
    .overlap_o (ov_21_c)
  );

  // Hit qualification, armed bookkeeping and round outcome for this frame
  always_comb begin
    p1_hit_c = (state_q == GS_FIGHT) && (bus.p1_state == HIT_STATE) &&
               ov_12_c && p1_armed_q;
    p2_hit_c = (state_q == GS_FIGHT) && (bus.p2_state == HIT_STATE) &&
               ov_21_c && p2_armed_q;

    // Landing a hit disarms; leaving the hit frames re-arms
    p1_armed_d = p1_armed_q;
    if (p1_hit_c)                        p1_armed_d = 1'b0;
    else if (bus.p1_state != HIT_STATE)  p1_armed_d = 1'b1;

    p2_armed_d = p2_armed_q;
    if (p2_hit_c)                        p2_armed_d = 1'b0;
    else if (bus.p2_state != HIT_STATE)  p2_armed_d = 1'b1;

    p1_health_d = p2_hit_c ? sat_dec(p1_health_q) : p1_health_q;
    p2_health_d = p1_hit_c ? sat_dec(p2_health_q) : p2_health_q;

    winner_d = WIN_NONE;
    if ((p1_health_d == '0) && (p2_health_d == '0)) winner_d = WIN_DRAW;
    else if (p2_health_d == '0)                     winner_d = WIN_P1;
    else if (p1_health_d == '0)                     winner_d = WIN_P2;
    ko_c = (winner_d != WIN_NONE);

    // A draw credits nobody; counters stop at the match target
    p1_wins_d = p1_wins_q;
    if ((winner_d == WIN_P1) && (p1_wins_q != WINS_MAX))
      p1_wins_d = p1_wins_q + WINS_W'(1);
    p2_wins_d = p2_wins_q;
    if ((winner_d == WIN_P2) && (p2_wins_q != WINS_MAX))
      p2_wins_d = p2_wins_q + WINS_W'(1);

    match_over_c = (p1_wins_q == WINS_MAX) || (p2_wins_q == WINS_MAX);
  end

  // Round sequencer and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= GS_FIGHT;
      winner_q      <= WIN_NONE;
      p1_health_q   <= HP_MAX;
      p2_health_q   <= HP_MAX;
      p1_took_hit_q <= 1'b0;
      p2_took_hit_q <= 1'b0;
      p1_wins_q     <= '0;
      p2_wins_q     <= '0;
      players_rst_q <= 1'b0;
      p1_armed_q    <= 1'b1;
      p2_armed_q    <= 1'b1;
      ko_cnt_q      <= '0;
    end else begin
      p1_took_hit_q <= 1'b0;
      p2_took_hit_q <= 1'b0;
      players_rst_q <= 1'b0;

      unique case (state_q)
        GS_FIGHT: begin
          if (bus.frame_tick) begin
            p1_health_q   <= p1_health_d;
            p2_health_q   <= p2_health_d;
            p1_took_hit_q <= p2_hit_c;
            p2_took_hit_q <= p1_hit_c;
            p1_armed_q    <= p1_armed_d;
            p2_armed_q    <= p2_armed_d;
            if (ko_c) begin
              state_q   <= GS_KO;
              winner_q  <= winner_d;
              p1_wins_q <= p1_wins_d;
              p2_wins_q <= p2_wins_d;
            end
          end
        end

        GS_KO: begin
          if (bus.frame_tick) begin
            p1_armed_q <= p1_armed_d;
            p2_armed_q <= p2_armed_d;
            // The tick that caused the KO is not counted here
            if (ko_cnt_q == KO_LAST) begin
              if (match_over_c) begin
                state_q <= GS_OVER;
              end else begin
                // Present the fresh round alongside the player reset pulse
                state_q       <= GS_RESTART;
                players_rst_q <= 1'b1;
                p1_health_q   <= HP_MAX;
                p2_health_q   <= HP_MAX;
                p1_armed_q    <= 1'b1;
                p2_armed_q    <= 1'b1;
                winner_q      <= WIN_NONE;
                ko_cnt_q      <= '0;
              end
            end else begin
              ko_cnt_q <= ko_cnt_q + KO_W'(1);
            end
          end
        end

        GS_RESTART: begin
          // Single cycle; any frame_tick seen here is dropped
          state_q    <= GS_FIGHT;
          p1_armed_q <= 1'b1;
          p2_armed_q <= 1'b1;
        end

        GS_OVER: begin
          state_q <= GS_OVER;
        end

        default: state_q <= GS_FIGHT;
      endcase
    end
  end

  assign bus.p1_health   = p1_health_q;
  assign bus.p2_health   = p2_health_q;
  assign bus.p1_took_hit = p1_took_hit_q;
  assign bus.p2_took_hit = p2_took_hit_q;
  assign bus.p1_wins     = p1_wins_q;
  assign bus.p2_wins     = p2_wins_q;
  assign bus.winner      = winner_q;
  assign bus.game_state  = state_q;
  assign bus.players_rst = players_rst_q;

endmodule

// File: tb/tb_combat_arbiter.sv
// Self-checking bench for combat_arbiter: a vector table for single-frame
// behaviour plus hand-written round, KO, OVER and reset sequences. Every
// cycle's expected outputs go through a scoreboard queue.
module tb_combat_arbiter;
  import combat_arbiter_pkg::*;

  typedef struct packed {
    logic [2:0] p1h;
    logic [2:0] p2h;
    logic       p1t;
    logic       p2t;
    logic [1:0] p1w;
    logic [1:0] p2w;
    logic [1:0] win;
    logic [1:0] gs;
    logic       prst;
  } out_t;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       g1;
    logic       g2;
    logic       tick;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  combat_arbiter_if bus ();

  combat_arbiter #(
    .MAX_HEALTH    (3),
    .ROUNDS_TO_WIN (2),
    .KO_FRAMES     (60),
    .HIT_STATE     (4'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  out_t        exp_q[$];
  string       name_q[$];
  out_t        e;
  vec_t        tv[17];

  function automatic out_t mk(input int p1h, input int p2h, input int p1t,
                              input int p2t, input int p1w, input int p2w,
                              input int win, input int gs, input int prst);
    out_t o;
    o.p1h  = 3'(p1h);
    o.p2h  = 3'(p2h);
    o.p1t  = 1'(p1t);
    o.p2t  = 1'(p2t);
    o.p1w  = 2'(p1w);
    o.p2w  = 2'(p2w);
    o.win  = 2'(win);
    o.gs   = 2'(gs);
    o.prst = 1'(prst);
    return o;
  endfunction

  function automatic vec_t v(input int s1, input int s2, input int g1,
                             input int g2, input int t, input out_t ex);
    vec_t r;
    r.s1   = 4'(s1);
    r.s2   = 4'(s2);
    r.g1   = 1'(g1);
    r.g2   = 1'(g2);
    r.tick = 1'(t);
    r.exp  = ex;
    return r;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("hp=%0d/%0d took=%0b/%0b wins=%0d/%0d winner=%0d gs=%0d prst=%0b",
                     o.p1h, o.p2h, o.p1t, o.p2t, o.p1w, o.p2w, o.win, o.gs, o.prst);
  endfunction

  function automatic out_t sample();
    out_t o;
    o.p1h  = bus.p1_health;
    o.p2h  = bus.p2_health;
    o.p1t  = bus.p1_took_hit;
    o.p2t  = bus.p2_took_hit;
    o.p1w  = bus.p1_wins;
    o.p2w  = bus.p2_wins;
    o.win  = bus.winner;
    o.gs   = bus.game_state;
    o.prst = bus.players_rst;
    return o;
  endfunction

  task automatic check_next();
    out_t  want;
    out_t  got;
    string nm;
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    got  = sample();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want));
    end
  endtask

  // One clock edge with the given tick; outputs sampled 1 unit after the edge
  task automatic step(input string nm, input logic tick, input out_t want);
    bus.frame_tick = tick;
    exp_q.push_back(want);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    check_next();
  endtask

  task automatic set_states(input logic [3:0] s1, input logic [3:0] s2);
    bus.p1_state = s1;
    bus.p2_state = s2;
  endtask

  // g1/g2 select touching (1) or one-pixel-apart (0) geometry per direction
  task automatic set_geom(input logic g1, input logic g2);
    bus.p1_hit_x1  = 10'd330; bus.p1_hit_x2  = 10'd448;
    bus.p1_hit_y1  = 10'd100; bus.p1_hit_y2  = 10'd200;
    bus.p2_hurt_x1 = 10'd501; bus.p2_hurt_x2 = g1 ? 10'd448 : 10'd449;
    bus.p2_hurt_y1 = 10'd250; bus.p2_hurt_y2 = 10'd50;
    bus.p1_hurt_x1 = 10'd300; bus.p1_hurt_x2 = 10'd360;
    bus.p1_hurt_y1 = 10'd100; bus.p1_hurt_y2 = 10'd300;
    bus.p2_hit_x1  = 10'd400; bus.p2_hit_x2  = g2 ? 10'd360 : 10'd361;
    bus.p2_hit_y1  = 10'd160; bus.p2_hit_y2  = 10'd150;
  endtask

  task automatic p1_strike();
    set_geom(1'b1, 1'b1);
    set_states(4'd5, 4'd0);
    e.p1t = 1'b0;
    e.p2t = 1'b0;
    step("p1_rearm", 1'b1, e);
    set_states(4'd4, 4'd0);
    e.p2h = e.p2h - 3'd1;
    e.p2t = 1'b1;
    if (e.p2h == 3'd0) begin
      e.gs  = 2'(GS_KO);
      e.win = 2'(WIN_P1);
      e.p1w = e.p1w + 2'd1;
    end
    step("p1_hit", 1'b1, e);
  endtask

  task automatic p2_strike();
    set_geom(1'b1, 1'b1);
    set_states(4'd0, 4'd5);
    e.p1t = 1'b0;
    e.p2t = 1'b0;
    step("p2_rearm", 1'b1, e);
    set_states(4'd0, 4'd4);
    e.p1h = e.p1h - 3'd1;
    e.p1t = 1'b1;
    if (e.p1h == 3'd0) begin
      e.gs  = 2'(GS_KO);
      e.win = 2'(WIN_P2);
      e.p2w = e.p2w + 2'd1;
    end
    step("p2_hit", 1'b1, e);
  endtask

  // n counted KO ticks with hits attempted (must be ignored), plus one idle cycle
  task automatic ko_ticks(input int n);
    set_geom(1'b1, 1'b1);
    set_states(4'd4, 4'd4);
    e.p1t = 1'b0;
    e.p2t = 1'b0;
    for (int i = 0; i < n; i++) begin
      step($sformatf("ko_hold%0d", i + 1), 1'b1, e);
      if (i == n / 2) step("ko_no_tick", 1'b0, e);
    end
  endtask

  task automatic ko_end(input logic to_over);
    if (to_over) begin
      e.gs = 2'(GS_OVER);
      step("ko_to_over", 1'b1, e);
    end else begin
      e = mk(3, 3, 0, 0, e.p1w, e.p2w, WIN_NONE, GS_RESTART, 1);
      step("ko_to_restart", 1'b1, e);
      e.gs   = 2'(GS_FIGHT);
      e.prst = 1'b0;
      step("restart_tick_ignored", 1'b1, e);
      set_states(4'd0, 4'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    set_states(4'd0, 4'd0);
    set_geom(1'b1, 1'b1);

    // Single-frame behaviour: hit once per attack, no-tick, edge contact, trade
    tv[0]  = v(0, 0, 1, 1, 1, mk(3, 3, 0, 0, 0, 0, 0, 0, 0));
    tv[1]  = v(4, 0, 1, 1, 0, mk(3, 3, 0, 0, 0, 0, 0, 0, 0));
    tv[2]  = v(4, 0, 1, 1, 1, mk(3, 2, 0, 1, 0, 0, 0, 0, 0));
    tv[3]  = v(4, 0, 1, 1, 0, mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
    tv[4]  = v(4, 0, 1, 1, 1, mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
    tv[5]  = v(4, 0, 1, 1, 1, mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
    tv[6]  = v(4, 0, 1, 1, 1, mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
    tv[7]  = v(4, 0, 1, 1, 1, mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
    tv[8]  = v(5, 0, 1, 1, 1, mk(3, 2, 0, 0, 0, 0, 0, 0, 0));
    tv[9]  = v(4, 0, 1, 1, 1, mk(3, 1, 0, 1, 0, 0, 0, 0, 0));
    tv[10] = v(0, 4, 1, 0, 1, mk(3, 1, 0, 0, 0, 0, 0, 0, 0));
    tv[11] = v(0, 4, 1, 1, 1, mk(2, 1, 1, 0, 0, 0, 0, 0, 0));
    tv[12] = v(4, 4, 0, 1, 1, mk(2, 1, 0, 0, 0, 0, 0, 0, 0));
    tv[13] = v(0, 0, 1, 1, 1, mk(2, 1, 0, 0, 0, 0, 0, 0, 0));
    tv[14] = v(0, 4, 1, 1, 1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tv[15] = v(5, 5, 1, 1, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tv[16] = v(4, 4, 1, 1, 1, mk(0, 0, 1, 1, 0, 0, 3, 1, 0));

    step("reset_values", 1'b1, mk(3, 3, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_states(tv[i].s1, tv[i].s2);
      set_geom(tv[i].g1, tv[i].g2);
      step($sformatf("vec%0d", i), tv[i].tick, tv[i].exp);
    end
    e = tv[16].exp;

    // Draw round: no credit, then a fresh round
    ko_ticks(59);
    ko_end(1'b0);

    // Overlap held without frame_tick
    set_geom(1'b1, 1'b1);
    set_states(4'd4, 4'd0);
    for (int i = 0; i < 100; i++) step("no_tick_hold", 1'b0, e);

    // P1 wins round one
    repeat (3) p1_strike();
    ko_ticks(59);
    ko_end(1'b0);

    // P1 wins round two and the match
    repeat (3) p1_strike();
    ko_ticks(59);
    ko_end(1'b1);
    for (int i = 0; i < 6; i++) begin
      set_states((i % 2 == 0) ? 4'd4 : 4'd5, (i % 2 == 0) ? 4'd4 : 4'd5);
      step("over_frozen", 1'b1, e);
    end

    // Reset out of OVER
    set_states(4'd0, 4'd0);
    rst = 1'b1;
    e   = mk(3, 3, 0, 0, 0, 0, 0, 0, 0);
    step("rst_from_over", 1'b1, e);
    rst = 1'b0;

    // P2 wins a round, reset lands on the 30th KO tick
    repeat (3) p2_strike();
    ko_ticks(29);
    rst = 1'b1;
    e   = mk(3, 3, 0, 0, 0, 0, 0, 0, 0);
    step("rst_mid_ko", 1'b1, e);
    rst = 1'b0;

    // Both players armed straight out of reset: a trade lands at once
    set_geom(1'b1, 1'b1);
    set_states(4'd4, 4'd4);
    step("armed_after_rst", 1'b1, mk(2, 2, 1, 1, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/combat_arbiter.md
# combat_arbiter

Round-level combat controller for the two-player fighter. Every game frame it checks each player's basic-attack hitbox against the opponent's main hurtbox. It applies damage at most once per attack, tracks health and round wins, and sequences rounds. Between rounds it pulses a reset to both player instances. It sits in the top level between the two player blocks and the renderer/HUD.

## Interface
Parameters:
- MAX_HEALTH, 3: hits needed to KO a player; health width is 3 bits, so MAX_HEALTH ≤ 7.
- ROUNDS_TO_WIN, 2: round wins needed to take the match; ≤ 3.
- KO_FRAMES, 60: frame ticks held in KO before the next round or match end.
- HIT_STATE, 4'd4: player state code that marks the active hit frames (basic attack end phase).

Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per game frame.
- p1_state, p2_state  in  4 each  player current_state.
- p1_hit_x1/x2/y1/y2, p2_hit_x1/x2/y1/y2  in  10 each  basic hithurtbox corners.
- p1_hurt_x1/x2/y1/y2, p2_hurt_x1/x2/y1/y2  in  10 each  main hurtbox corners. x1 > x2 is legal; the right-side player reports them swapped.
- p1_health, p2_health  out  3  remaining health.
- p1_took_hit, p2_took_hit  out  1  one-cycle pulse when that player is damaged.
- p1_wins, p2_wins  out  2  rounds won.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- game_state  out  2  00 FIGHT, 01 KO, 10 RESTART, 11 OVER.
- players_rst  out  1  one-cycle reset pulse to both players.

## Operation
- Each box's x and y pair is normalized to (min, max) before comparison.
- Overlap is inclusive: a.lo ≤ b.hi and b.lo ≤ a.hi, required on both axes.
- P1 lands a hit when all of the following hold:
  - p1_state == HIT_STATE
  - P1 hitbox overlaps P2 hurtbox
  - p1_armed is set
- P2 is symmetric.
- Armed flags:
  - Set to 1 on reset and on RESTART.
  - Cleared when that player lands a hit.
  - Re-set on any tick where that player's state != HIT_STATE.
  - Result: one hit per attack.
- FIGHT, on frame_tick only:
  - Each landed hit decrements the victim's health by 1, saturating at 0, and pulses its took_hit.
  - Simultaneous hits on both players are a trade: both decrement.
- FIGHT to KO, on the same edge that any health reaches 0:
  - Only P2 at 0: winner = 01, p1_wins += 1.
  - Only P1 at 0: winner = 10, p2_wins += 1.
  - Both at 0: winner = 11, no win increment.
- KO:
  - Hit evaluation is disabled; the KO frame counter increments on each tick.
  - After KO_FRAMES ticks, go to OVER if either wins count == ROUNDS_TO_WIN, else go to RESTART.
- RESTART (lasts one cycle):
  - players_rst = 1.
  - Health reloads to MAX_HEALTH.
  - Armed flags are set; winner and the KO counter are cleared.
  - Next state is FIGHT.
- OVER: all outputs frozen; only rst exits.
- Wins counters saturate at ROUNDS_TO_WIN.

## Timing
- Reset values:
  - p1_health = p2_health = MAX_HEALTH
  - took_hit pulses 0, wins 0, winner 00
  - game_state FIGHT, players_rst 0
  - armed = 1, KO counter 0
- rst has priority over every other event in the same cycle, in any state including mid-KO.
- Latency: a frame_tick at edge N produces health, took_hit, winner and game_state at N+1. took_hit deasserts at N+2.
- Without frame_tick, no health, armed or KO-counter change occurs.
- The KO-to-RESTART/OVER transition happens on the edge of the KO_FRAMES-th tick counted in KO. The tick that caused the KO does not count.
- players_rst is high for exactly one cycle, the cycle spent in RESTART. A frame_tick arriving during RESTART is ignored.

## Structure
- Shared package holds:
  - Player state codes, with HIT_STATE taken from there.
  - game_state encoding.
  - winner encoding.
- Sub-module box_overlap: combinational. It takes two boxes with unordered corners and outputs a 1-bit overlap. Instantiate it twice, once for P1→P2 and once for P2→P1.

## Test plan
- Clean hit:
  - Stimulus: p1_state = 4 with overlapping boxes for 5 ticks.
  - Response: p2_health 3→2 once; p2_took_hit pulses once, one cycle after the first tick.
  - Then: p1_state = 5 for one tick, back to 4 → second hit, p2_health = 1.
- Trade:
  - Stimulus: both players in state 4, mutually overlapping, both health 1.
  - Response: both health 0, winner = 11, wins unchanged, game_state KO.
- Swapped hurtbox:
  - Stimulus: P2 hurt x1 = 501, x2 = 448; P1 hitbox x = 330..448.
  - Response: hit registered; edge contact counts as overlap.
- Round flow:
  - Stimulus: P1 KOs P2.
  - Response: after 60 ticks, RESTART for one cycle with players_rst = 1; health back to 3; p1_wins = 1.
  - Then: a second KO by P1 → OVER, outputs frozen.
- No tick, no effect: overlap held with frame_tick = 0 for 100 cycles → health unchanged.
- Reset mid-KO: rst asserted at KO tick 30 → next cycle shows all reset values and game_state FIGHT.
